// File: rtl/id_x_pipe.sv
// ID->X pipeline register: stall hold, redirect flush with multi-cycle kill window,
// bubble insertion/counting and combinational load-use detection for the 3-stage core.
module id_x_pipe #(
   parameter int          DWIDTH       = 32,
   parameter int          FLUSH_CYCLES = 2,
   parameter logic [31:0] NOP_INST     = 32'h0000_0013
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [DWIDTH-1:0] id_pc,
   input  logic [31:0]       id_inst,
   input  logic [DWIDTH-1:0] id_rs1_data,
   input  logic [DWIDTH-1:0] id_rs2_data,
   input  logic [4:0]        id_rs1,
   input  logic [4:0]        id_rs2,
   input  logic [4:0]        id_rd,
   input  logic              id_rf_wen,
   output logic              x_valid,
   output logic [DWIDTH-1:0] x_pc,
   output logic [31:0]       x_inst,
   output logic [DWIDTH-1:0] x_rs1_data,
   output logic [DWIDTH-1:0] x_rs2_data,
   output logic [4:0]        x_rs1,
   output logic [4:0]        x_rs2,
   output logic [4:0]        x_rd,
   output logic              x_rf_wen,
   output logic [6:0]        x_opcode,
   output logic              load_use,
   output logic [31:0]       bubble_cnt
);

   localparam logic [6:0] OPC_LOAD    = 7'b000_0011;
   localparam logic [2:0] KILL_RELOAD = 3'(FLUSH_CYCLES - 1);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_KILL = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [2:0]        kill_cnt_q, kill_cnt_d;
   logic [31:0]       bubble_cnt_q, bubble_cnt_d;
   logic              x_valid_q, x_valid_d;
   logic [DWIDTH-1:0] x_pc_q, x_pc_d;
   logic [31:0]       x_inst_q, x_inst_d;
   logic [DWIDTH-1:0] x_rs1_data_q, x_rs1_data_d;
   logic [DWIDTH-1:0] x_rs2_data_q, x_rs2_data_d;
   logic [4:0]        x_rs1_q, x_rs1_d;
   logic [4:0]        x_rs2_q, x_rs2_d;
   logic [4:0]        x_rd_q, x_rd_d;
   logic              x_rf_wen_q, x_rf_wen_d;
   logic              bubble;

   always_comb begin
      // NOTE: every signal gets a hold default first so no path can infer a latch.
      state_d      = state_q;
      kill_cnt_d   = kill_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      x_valid_d    = x_valid_q;
      x_pc_d       = x_pc_q;
      x_inst_d     = x_inst_q;
      x_rs1_data_d = x_rs1_data_q;
      x_rs2_data_d = x_rs2_data_q;
      x_rs1_d      = x_rs1_q;
      x_rs2_d      = x_rs2_q;
      x_rd_d       = x_rd_q;
      x_rf_wen_d   = x_rf_wen_q;
      bubble       = 1'b0;

      if (flush) begin
         bubble     = 1'b1;
         kill_cnt_d = KILL_RELOAD;
         state_d    = (FLUSH_CYCLES == 1) ? ST_RUN : ST_KILL;
      end else if (stall) begin
         bubble = 1'b0;
      end else if (state_q == ST_KILL) begin
         bubble = 1'b1;
         if (kill_cnt_q <= 3'd1) begin
            kill_cnt_d = 3'd0;
            state_d    = ST_RUN;
         end else begin
            kill_cnt_d = kill_cnt_q - 3'd1;
         end
      end else if (!id_valid) begin
         bubble = 1'b1;
      end else begin
         x_valid_d    = 1'b1;
         x_pc_d       = id_pc;
         x_inst_d     = id_inst;
         x_rs1_data_d = id_rs1_data;
         x_rs2_data_d = id_rs2_data;
         x_rs1_d      = id_rs1;
         x_rs2_d      = id_rs2;
         x_rd_d       = id_rd;
         x_rf_wen_d   = id_rf_wen & (id_rd != 5'd0);
      end

      // Bubbles keep x_pc and operand data; only the control/identity fields are cleared.
      if (bubble) begin
         x_valid_d    = 1'b0;
         x_rf_wen_d   = 1'b0;
         x_rd_d       = 5'd0;
         x_rs1_d      = 5'd0;
         x_rs2_d      = 5'd0;
         x_inst_d     = NOP_INST;
         bubble_cnt_d = bubble_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q      <= ST_RUN;
         kill_cnt_q   <= 3'd0;
         bubble_cnt_q <= 32'd0;
         x_valid_q    <= 1'b0;
         x_pc_q       <= '0;
         x_inst_q     <= NOP_INST;
         x_rs1_data_q <= '0;
         x_rs2_data_q <= '0;
         x_rs1_q      <= 5'd0;
         x_rs2_q      <= 5'd0;
         x_rd_q       <= 5'd0;
         x_rf_wen_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         kill_cnt_q   <= kill_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
         x_valid_q    <= x_valid_d;
         x_pc_q       <= x_pc_d;
         x_inst_q     <= x_inst_d;
         x_rs1_data_q <= x_rs1_data_d;
         x_rs2_data_q <= x_rs2_data_d;
         x_rs1_q      <= x_rs1_d;
         x_rs2_q      <= x_rs2_d;
         x_rd_q       <= x_rd_d;
         x_rf_wen_q   <= x_rf_wen_d;
      end
   end

   assign x_valid    = x_valid_q;
   assign x_pc       = x_pc_q;
   assign x_inst     = x_inst_q;
   assign x_rs1_data = x_rs1_data_q;
   assign x_rs2_data = x_rs2_data_q;
   assign x_rs1      = x_rs1_q;
   assign x_rs2      = x_rs2_q;
   assign x_rd       = x_rd_q;
   assign x_rf_wen   = x_rf_wen_q;
   assign x_opcode   = x_inst_q[6:0];
   assign bubble_cnt = bubble_cnt_q;

   assign load_use = x_valid_q & (x_inst_q[6:0] == OPC_LOAD) & (x_rd_q != 5'd0) &
                     ((x_rd_q == id_rs1) | (x_rd_q == id_rs2));

endmodule
